// File: rtl/rtl_pkt_arb4.sv
// rtl_pkt_arb4: four-requester packet arbiter with round-robin grant.
// A packet owns the output stream from its start word to its end word.
// Words arriving without a grant and without sop are orphans and are dropped.
// Optional mid-packet starvation timeout is enabled by defining the macro
// RTL_PKT_ARB4_TMO_EN. The default build has no timeout and oerr is tied low.
module rtl_pkt_arb4 #(
    parameter int WID = 32,
    parameter int NOB = 2,
    parameter int TMO = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           ivld,
    input  logic [3:0]           isop,
    input  logic [3:0]           ieop,
    input  logic [4*WID-1:0]     idat,
    input  logic [4*NOB-1:0]     inob,
    output logic [3:0]           oack,
    output logic [WID-1:0]       odat,
    output logic [NOB-1:0]       onob,
    output logic                 ovld,
    output logic                 osop,
    output logic                 oeop,
    output logic [1:0]           osrc,
    output logic                 oerr,
    output logic                 odrop
);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [1:0]     r_ptr;
    logic [1:0]     w_ptrNext;
    logic [1:0]     r_g;
    logic [1:0]     w_gNext;
    logic           r_first;
    logic           w_firstNext;

    logic [3:0]     w_cand;
    logic [3:0]     w_orphan;
    logic [3:0]     w_dropSel;
    logic [3:0]     w_ack;
    logic           w_hasCand;
    logic [1:0]     w_win;
    logic [1:0]     w_idx;
    logic           w_accept;
    logic           w_acceptEop;
    logic           w_drop;
    logic           w_timeout;
    logic [WID-1:0] w_dat;
    logic [NOB-1:0] w_nob;

    // Start-of-packet requests compete for the grant; non-sop words seen
    // while idle belong to no packet and are dropped lowest index first.
    assign w_cand    = ivld & isop;
    assign w_orphan  = ivld & ~isop;
    assign w_dropSel = w_orphan & (~w_orphan + 4'd1);
    assign w_drop    = (r_state == ST_IDLE) && (|w_orphan);

    assign w_accept    = (r_state == ST_XFER) && ivld[r_g];
    assign w_acceptEop = w_accept && ieop[r_g];
    assign w_dat       = idat[r_g*WID +: WID];
    assign w_nob       = inob[r_g*NOB +: NOB];

    // Round-robin pick: scan downward from the farthest offset so the
    // candidate closest to the pointer is the last (winning) assignment.
    always_comb begin
        w_hasCand = 1'b0;
        w_win     = r_ptr;
        w_idx     = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_cand[w_idx]) begin
                w_hasCand = 1'b1;
                w_win     = w_idx;
            end
        end
    end

    // Accept strobes: only the granted requester in XFER, only the chosen
    // orphan in IDLE, nothing while reset is held.
    always_comb begin
        w_ack = 4'd0;
        if (rst) begin
            if (r_state == ST_XFER) begin
                if (ivld[r_g]) begin
                    w_ack = 4'd1 << r_g;
                end
            end else begin
                w_ack = w_dropSel;
            end
        end
    end

    assign oack = w_ack;

`ifdef RTL_PKT_ARB4_TMO_EN
    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [TW-1:0] r_tmoCnt;
    logic          r_oerr;

    // Fire when one more starved cycle would bring the counter to the limit.
    assign w_timeout = (r_state == ST_XFER) && !ivld[r_g] && (r_tmoCnt == TW'(TMO - 1));

    // Starvation counter: cleared by any accepted word, counts idle XFER cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmoCnt <= '0;
        end else if (r_state != ST_XFER || w_accept || w_timeout) begin
            r_tmoCnt <= '0;
        end else begin
            r_tmoCnt <= r_tmoCnt + TW'(1);
        end
    end

    // Error flag accompanies the forced end-of-packet word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oerr <= 1'b0;
        end else begin
            r_oerr <= w_timeout;
        end
    end

    assign oerr = r_oerr;
`else
    assign w_timeout = 1'b0;
    assign oerr      = 1'b0;
`endif

    // FSM state, grant, round-robin pointer and first-word flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_g     <= 2'd0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_g     <= w_gNext;
            r_first <= w_firstNext;
        end
    end

    // Next-state logic: grant on a sop candidate, release on eop or timeout.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_gNext     = r_g;
        w_firstNext = r_first;
        case (r_state)
            ST_IDLE: begin
                if (w_hasCand) begin
                    w_stateNext = ST_XFER;
                    w_gNext     = w_win;
                    w_firstNext = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_acceptEop || w_timeout) begin
                    w_stateNext = ST_IDLE;
                    w_ptrNext   = r_g + 2'd1;
                    w_firstNext = 1'b0;
                end else if (w_accept) begin
                    w_firstNext = 1'b0;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Registered output stream; sop marks only the first word of the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovld  <= 1'b0;
            osop  <= 1'b0;
            oeop  <= 1'b0;
            odrop <= 1'b0;
            odat  <= '0;
            onob  <= '0;
            osrc  <= 2'd0;
        end else begin
            ovld  <= w_accept || w_timeout;
            osop  <= w_accept && r_first;
            oeop  <= w_acceptEop || w_timeout;
            odrop <= w_drop;
            if (w_accept) begin
                odat <= w_dat;
                onob <= w_nob;
                osrc <= r_g;
            end else if (w_timeout) begin
                odat <= '0;
                onob <= '0;
                osrc <= r_g;
            end
        end
    end

endmodule

// File: tb/tb_rtl_pkt_arb4.sv
// tb_rtl_pkt_arb4: directed scoreboard bench for rtl_pkt_arb4.
// Per-requester source queues drive the inputs; expected output words are
// queued by hand and a monitor pops and compares each valid output word.
module tb_rtl_pkt_arb4;

    localparam int WID = 32;
    localparam int NOB = 2;
    localparam int TMO = 4;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [31:0] dat;
        logic [1:0]  nob;
        int          hold;
    } srcWord_t;

    typedef struct {
        logic [1:0]  src;
        logic        sop;
        logic        eop;
        logic        err;
        logic [31:0] dat;
        logic [1:0]  nob;
        int          gap;
    } expWord_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       ivld;
    logic [3:0]       isop;
    logic [3:0]       ieop;
    logic [4*WID-1:0] idat;
    logic [4*NOB-1:0] inob;
    logic [3:0]       oack;
    logic [WID-1:0]   odat;
    logic [NOB-1:0]   onob;
    logic             ovld;
    logic             osop;
    logic             oeop;
    logic [1:0]       osrc;
    logic             oerr;
    logic             odrop;

    srcWord_t srcQ[4][$];
    expWord_t expQ[$];

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int lastOut = 0;
    int dropSeen = 0;
    int dropStart = 0;

    rtl_pkt_arb4 #(.WID(WID), .NOB(NOB), .TMO(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .ivld  (ivld),
        .isop  (isop),
        .ieop  (ieop),
        .idat  (idat),
        .inob  (inob),
        .oack  (oack),
        .odat  (odat),
        .onob  (onob),
        .ovld  (ovld),
        .osop  (osop),
        .oeop  (oeop),
        .osrc  (osrc),
        .oerr  (oerr),
        .odrop (odrop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic addSrc(input int r, input logic sop, input logic eop,
                          input logic [31:0] dat, input logic [1:0] nob, input int hold);
        srcWord_t w;
        w.sop = sop; w.eop = eop; w.dat = dat; w.nob = nob; w.hold = hold;
        srcQ[r].push_back(w);
    endtask

    task automatic addExp(input logic [1:0] src, input logic sop, input logic eop, input logic err,
                          input logic [31:0] dat, input logic [1:0] nob, input int gap);
        expWord_t e;
        e.src = src; e.sop = sop; e.eop = eop; e.err = err; e.dat = dat; e.nob = nob; e.gap = gap;
        expQ.push_back(e);
    endtask

    // Source model: present each requester's head word at the falling edge,
    // then pop words that were accepted just before the next rising edge.
    initial begin
        srcWord_t   w;
        logic [3:0] acc;
        ivld = '0; isop = '0; ieop = '0; idat = '0; inob = '0;
        forever begin
            @(negedge clk);
            ivld = '0; isop = '0; ieop = '0; idat = '0; inob = '0;
            for (int i = 0; i < 4; i++) begin
                if (srcQ[i].size() > 0) begin
                    w = srcQ[i][0];
                    if (w.hold > 0) begin
                        w.hold--;
                        srcQ[i][0] = w;
                    end else begin
                        ivld[i] = 1'b1;
                        isop[i] = w.sop;
                        ieop[i] = w.eop;
                        idat[i*WID +: WID] = w.dat;
                        inob[i*NOB +: NOB] = w.nob;
                    end
                end
            end
            #4;
            acc = ivld & oack;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && srcQ[i].size() > 0) begin
                    void'(srcQ[i].pop_front());
                end
            end
        end
    end

    // Monitor: compare every valid output word against the scoreboard head.
    initial begin
        expWord_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (odrop) dropSeen++;
            if (ovld) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected word: got src=%0d dat=%0h, required none", osrc, odat);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("osrc", 64'(osrc), 64'(e.src));
                    checkOutput("osop", 64'(osop), 64'(e.sop));
                    checkOutput("oeop", 64'(oeop), 64'(e.eop));
                    checkOutput("oerr", 64'(oerr), 64'(e.err));
                    checkOutput("odat", 64'(odat), 64'(e.dat));
                    checkOutput("onob", 64'(onob), 64'(e.nob));
                    if (e.gap > 0) checkOutput("gap", 64'(cycle - lastOut), 64'(e.gap));
                end
                lastOut = cycle;
            end
        end
    end

    task automatic assertReset();
        rst = 1'b0;
        #1;
        checkOutput("reset ovld", 64'(ovld), 64'd0);
        checkOutput("reset osop", 64'(osop), 64'd0);
        checkOutput("reset oeop", 64'(oeop), 64'd0);
        checkOutput("reset oerr", 64'(oerr), 64'd0);
        checkOutput("reset odrop", 64'(odrop), 64'd0);
        checkOutput("reset odat", 64'(odat), 64'd0);
        checkOutput("reset onob", 64'(onob), 64'd0);
        checkOutput("reset osrc", 64'(osrc), 64'd0);
        checkOutput("reset oack", 64'(oack), 64'd0);
        for (int i = 0; i < 4; i++) srcQ[i].delete();
        expQ.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitDrain(input int maxCyc);
        int n = 0;
        while (expQ.size() != 0 && n < maxCyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d words still expected, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Directed vectors; expected words carry hand-computed gaps in cycles.
    task automatic applyStimulus(input int id);
        dropStart = dropSeen;
        case (id)
            0: begin
                addSrc(0, 1, 0, 32'hA000_0000, 2'd0, 0);
                addSrc(0, 0, 0, 32'hA000_0001, 2'd1, 2);
                addSrc(0, 0, 1, 32'hA000_0002, 2'd3, 0);
                addSrc(2, 1, 0, 32'hC000_0000, 2'd2, 0);
                addSrc(2, 1, 0, 32'hC000_0001, 2'd1, 0);
                addSrc(2, 0, 1, 32'hC000_0002, 2'd0, 0);
                addExp(0, 1, 0, 0, 32'hA000_0000, 2'd0, 0);
                addExp(0, 0, 0, 0, 32'hA000_0001, 2'd1, 3);
                addExp(0, 0, 1, 0, 32'hA000_0002, 2'd3, 1);
                addExp(2, 1, 0, 0, 32'hC000_0000, 2'd2, 2);
                addExp(2, 0, 0, 0, 32'hC000_0001, 2'd1, 1);
                addExp(2, 0, 1, 0, 32'hC000_0002, 2'd0, 1);
            end
            1: begin
                addSrc(0, 1, 1, 32'h1000_0000, 2'd1, 0);
                addSrc(0, 1, 1, 32'h1000_0004, 2'd2, 0);
                addSrc(1, 1, 1, 32'h1100_0001, 2'd3, 0);
                addSrc(2, 1, 1, 32'h1200_0002, 2'd0, 0);
                addSrc(3, 1, 1, 32'h1300_0003, 2'd1, 0);
                addExp(0, 1, 1, 0, 32'h1000_0000, 2'd1, 0);
                addExp(1, 1, 1, 0, 32'h1100_0001, 2'd3, 2);
                addExp(2, 1, 1, 0, 32'h1200_0002, 2'd0, 2);
                addExp(3, 1, 1, 0, 32'h1300_0003, 2'd1, 2);
                addExp(0, 1, 1, 0, 32'h1000_0004, 2'd2, 2);
            end
            2: begin
                addSrc(1, 1, 1, 32'h2100_0001, 2'd2, 0);
                addSrc(3, 0, 0, 32'h2300_0003, 2'd1, 0);
                addExp(1, 1, 1, 0, 32'h2100_0001, 2'd2, 0);
            end
            3: begin
                for (int k = 0; k < 5; k++) begin
                    addSrc(0, k == 0, k == 4, 32'h3000_0000 + 32'(k), 2'(k), 0);
                end
                addExp(0, 1, 0, 0, 32'h3000_0000, 2'd0, 0);
            end
            4: begin
                addSrc(0, 1, 1, 32'h4000_0000, 2'd3, 0);
                addSrc(3, 1, 1, 32'h4300_0003, 2'd2, 0);
                addExp(0, 1, 1, 0, 32'h4000_0000, 2'd3, 0);
                addExp(3, 1, 1, 0, 32'h4300_0003, 2'd2, 2);
            end
            5: begin
                addSrc(0, 1, 0, 32'h5000_0000, 2'd1, 0);
                addSrc(0, 0, 0, 32'h5000_0001, 2'd2, 8);
                addSrc(0, 0, 1, 32'h5000_0002, 2'd3, 0);
                addSrc(1, 1, 1, 32'h5100_0001, 2'd0, 0);
                addExp(0, 1, 0, 0, 32'h5000_0000, 2'd1, 0);
                addExp(0, 0, 1, 1, 32'h0000_0000, 2'd0, 4);
                addExp(1, 1, 1, 0, 32'h5100_0001, 2'd0, 2);
            end
            default: begin
            end
        endcase
    endtask

    initial begin
        #1;
        assertReset();

        // Two 3-word packets at reset release, requester 0 first.
        applyStimulus(0);
        releaseReset();
        waitDrain(100);
        idleCycles(6);
        checkOutput("drops A", 64'(dropSeen - dropStart), 64'd0);

        // All requesters with single-word packets: strict rotation.
        assertReset();
        applyStimulus(1);
        releaseReset();
        waitDrain(100);
        idleCycles(6);
        checkOutput("drops B", 64'(dropSeen - dropStart), 64'd0);

        // Orphan word in IDLE alongside a valid single-word packet.
        assertReset();
        applyStimulus(2);
        releaseReset();
        waitDrain(100);
        idleCycles(6);
        checkOutput("drops C", 64'(dropSeen - dropStart), 64'd1);

        // Reset mid-packet, pointer left at 2 beforehand.
        applyStimulus(3);
        waitDrain(100);
        assertReset();
        applyStimulus(4);
        releaseReset();
        waitDrain(100);
        idleCycles(6);
        checkOutput("drops E", 64'(dropSeen - dropStart), 64'd0);

`ifdef RTL_PKT_ARB4_TMO_EN
        // Starved packet is force-closed, its leftovers become orphans.
        assertReset();
        applyStimulus(5);
        releaseReset();
        waitDrain(100);
        idleCycles(14);
        checkOutput("drops F", 64'(dropSeen - dropStart), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtl_pkt_arb4.md
RTL_PKT_ARB4 -- requirements
Module: rtl_pkt_arb4

Interface
REQ-001 Parameter WID, default 32: data word width per requester and on the output.
REQ-002 Parameter NOB, default 2: width of the per-word byte-count field.
REQ-003 Parameter TMO, default 255: mid-packet starvation limit in cycles; used only when RTL_PKT_ARB4_TMO_EN is defined.
REQ-004 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port ivld, input, 4: per-requester word valid; bit i belongs to requester i.
REQ-007 Port isop, input, 4: per-requester start of packet, qualified by ivld.
REQ-008 Port ieop, input, 4: per-requester end of packet, qualified by ivld.
REQ-009 Port idat, input, 4*WID: requester i drives bits [i*WID +: WID].
REQ-010 Port inob, input, 4*NOB: requester i drives bits [i*NOB +: NOB].
REQ-011 Port oack, output, 4: combinational accept; a word is consumed when ivld[i] and oack[i] are both high.
REQ-012 Ports odat (WID), onob (NOB), ovld, osop, oeop, output: registered stream to the x4 packer.
REQ-013 Port osrc, output, 2: index of the requester that owns the current output word.
REQ-014 Port oerr, output, 1: output word is a forced (error) end of packet.
REQ-015 Port odrop, output, 1: one-cycle pulse when an orphan word is discarded.

Function
REQ-016 FSM has two states: IDLE and XFER.
REQ-017 IDLE: the candidates are the requesters with ivld & isop; the first candidate scanning upward from pointer ptr (modulo 4) wins; grant register g is loaded with it; the FSM moves to XFER; no word is accepted in this cycle.
REQ-018 IDLE: a requester with ivld & ~isop gets oack=1, its word is discarded, and odrop pulses on the next cycle; if several requesters do this, the lowest index is dropped first.
REQ-019 XFER: oack[g] = ivld[g]; every other oack bit is 0.
REQ-020 An accepted word appears on odat/onob/osop/oeop/osrc with ovld=1 exactly 1 cycle later; otherwise ovld=0 and osop, oeop and oerr are 0.
REQ-021 In XFER, an accepted word with isop set is passed through unchanged; osop is not re-asserted after the first word; the first accepted word always has osop=1.
REQ-022 Accepted word with ieop: the FSM returns to IDLE and ptr is set to (g+1) mod 4; at least 1 bubble cycle separates packets.
REQ-023 A single-word packet (isop & ieop) takes one XFER cycle and produces osop=oeop=1 on the same output word.
REQ-024 A new request that arrives in the same cycle as an eop acceptance is arbitrated in the following IDLE cycle, never in the current cycle.
REQ-025 A requester with no valid word in XFER stalls the grant; without the timeout feature, the grant is held indefinitely.

Reset
REQ-026 While rst=0: state=IDLE, ptr=0, g=0, oack=0, and ovld, osop, oeop, oerr, odrop=0; odat=0, onob=0, osrc=0.
REQ-027 Reset asserted mid-packet aborts the packet silently, with no oeop and no oerr; after release, arbitration restarts from requester 0.

Configuration
REQ-028 Macro RTL_PKT_ARB4_TMO_EN defined: a counter clears on every accepted word and increments on each XFER cycle with ~ivld[g]; the counter reaching TMO causes the following:
REQ-029 (timeout) one output word with ovld=1, oeop=1, oerr=1, odat=0, onob=0, osrc=g; the FSM goes to IDLE; ptr=(g+1) mod 4; later words from g up to its eop are orphans, dropped per REQ-018.
REQ-030 Macro undefined: no counter exists, oerr is tied to 0, and REQ-025 applies.

Verification
REQ-031 Requesters 0 and 2 each offer a 3-word packet at reset release -> requester 0 goes first (osrc=0, osop on word 1, oeop on word 3), then 1 bubble, then requester 2's packet.
REQ-032 All 4 requesters hold 1-word packets continuously -> osrc sequence 0,1,2,3,0 with ovld on alternate cycles.
REQ-033 Requester 1 sends a 1-word packet while requester 3 has ivld=1, isop=0 in IDLE -> odrop pulses once, and requester 1's word is output with osop=oeop=1.
REQ-034 With the macro defined and TMO=4, requester 0 sends sop then stalls for 4 cycles -> 1 output word with oeop=1, oerr=1, osrc=0, and the next grant goes to requester 1 if it is requesting.
REQ-035 rst pulled low during word 2 of a 5-word packet -> all outputs are 0 asynchronously; after release, the next packet starts with osop and osrc=0 if requester 0 is requesting.
